// File: rtl/wisc_cache_pkg.sv
// Shared types and constants for the WISC cache miss-handling logic.
// Block geometry, fill FSM state encoding and a block-base helper.
package wisc_cache_pkg;

    localparam int ADDR_WIDTH        = 16;
    localparam int WORDS_PER_BLOCK   = 8;
    localparam int MEM_LATENCY       = 4;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;
    localparam int CNT_WIDTH         = WORD_IDX_BITS + 1;

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        ADDR_WIDTH'((1 << BLOCK_OFFSET_BITS) - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Clears the byte offset so every issued address lands inside the missing block.
    function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Small word counter used for both the issue and receive sides of a block fill.
// Synchronous clear, enable, and a flag that holds the count once it reaches TERMINAL.
module fill_word_counter
    import wisc_cache_pkg::*;
#(
    parameter int TERMINAL = WORDS_PER_BLOCK
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 terminal
);

    assign terminal = (count == CNT_WIDTH'(TERMINAL));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: streams one block of word reads to memory and
// writes the returned words into the data array, committing the tag last.
module cache_fill_fsm
    import wisc_cache_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_detected,
    input  logic [ADDR_WIDTH-1:0]    miss_address,
    input  logic                     memory_data_valid,
    input  logic [ADDR_WIDTH-1:0]    memory_data,
    output logic                     fsm_busy,
    output logic                     memory_read,
    output logic [ADDR_WIDTH-1:0]    memory_address,
    output logic                     write_data_array,
    output logic [WORD_IDX_BITS-1:0] data_array_word,
    output logic [ADDR_WIDTH-1:0]    data_out,
    output logic                     write_tag_array,
    output logic                     fill_done,
    output logic [ADDR_WIDTH-1:0]    fill_count
);

    fill_state_e           state_q;
    fill_state_e           state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] fill_cnt_q;
    logic [CNT_WIDTH-1:0]  issue_cnt;
    logic [CNT_WIDTH-1:0]  recv_cnt;
    logic                  issue_term;
    logic                  recv_term;
    logic                  start_fill;
    logic                  recv_en;
    logic                  last_word;

    assign start_fill = (state_q == IDLE) && miss_detected;
    assign recv_en    = (state_q == FILL) && memory_data_valid && !recv_term;
    assign last_word  = recv_en && (recv_cnt == CNT_WIDTH'(WORDS_PER_BLOCK - 1));

    fill_word_counter #(.TERMINAL(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_fill),
        .enable   (state_q == FILL),
        .count    (issue_cnt),
        .terminal (issue_term)
    );

    fill_word_counter #(.TERMINAL(WORDS_PER_BLOCK)) u_recv_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_fill),
        .enable   (recv_en),
        .count    (recv_cnt),
        .terminal (recv_term)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q     <= '0;
            fill_cnt_q <= '0;
        end else begin
            if (start_fill) begin
                base_q <= block_base(miss_address);
            end
            if (last_word) begin
                fill_cnt_q <= fill_cnt_q + ADDR_WIDTH'(1);
            end
        end
    end

    // NOTE: every combinational output is given a default before the case
    // logic, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (miss_detected) state_d = FILL;
            FILL: if (last_word)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything is forced low while rst is asserted, even before the reset edge lands.
    always_comb begin
        fsm_busy         = 1'b0;
        memory_read      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        data_array_word  = '0;
        data_out         = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        fill_count       = rst ? fill_cnt_q : '0;
        if (rst && (state_q == FILL)) begin
            fsm_busy = 1'b1;
            if (!issue_term) begin
                memory_read    = 1'b1;
                memory_address = base_q | ADDR_WIDTH'({issue_cnt, 1'b0});
            end
            if (recv_en) begin
                write_data_array = 1'b1;
                data_array_word  = recv_cnt[WORD_IDX_BITS-1:0];
                data_out         = memory_data;
            end
            if (last_word) begin
                write_tag_array = 1'b1;
                fill_done       = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed scenarios with randomized
// addresses, data and return gaps, checked cycle by cycle against a fill model.
module tb_cache_fill_fsm;
    import wisc_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  data_array_word;
    logic [15:0] data_out;
    logic        write_tag_array;
    logic        fill_done;
    logic [15:0] fill_count;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_array_word   (data_array_word),
        .data_out          (data_out),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done),
        .fill_count        (fill_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Fill model: one outstanding block, counted in words issued and received.
    bit          m_busy   = 1'b0;
    logic [15:0] m_base   = '0;
    int          m_issued = 0;
    int          m_recv   = 0;
    logic [15:0] m_fills  = '0;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;
    rd_t memq[$];

    int gap_max      = 0;
    int next_ok      = 0;
    int n_writes     = 0;
    int n_tags       = 0;
    int last_tag_cyc = -1;
    int miss_cyc     = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    // One clock: drive inputs, compare every output at the negedge, advance the model.
    task automatic step(input bit r, input bit miss, input logic [15:0] maddr, input bit mem_on);
        bit          v;
        logic [15:0] d;
        bit          e_busy;
        bit          e_rd;
        bit          e_wr;
        bit          e_tag;
        rst           = r;
        miss_detected = miss;
        miss_address  = maddr;
        v = 1'b0;
        d = '0;
        if (mem_on && memq.size() > 0 && memq[0].due <= cyc && cyc >= next_ok) begin
            v = 1'b1;
            d = mem_word(memq[0].addr);
            void'(memq.pop_front());
            next_ok = cyc + 1 + int'($urandom_range(gap_max, 0));
        end
        memory_data_valid = v;
        memory_data       = v ? d : 16'($urandom);
        @(negedge clk);
        e_busy = r && m_busy;
        e_rd   = e_busy && (m_issued < WORDS_PER_BLOCK);
        e_wr   = e_busy && v;
        e_tag  = e_wr && (m_recv == WORDS_PER_BLOCK - 1);
        check("fsm_busy", fsm_busy, e_busy);
        check("memory_read", memory_read, e_rd);
        check("memory_address", memory_address, e_rd ? m_base + 16'(2 * m_issued) : 16'h0);
        check("write_data_array", write_data_array, e_wr);
        check("data_array_word", data_array_word, e_wr ? m_recv : 0);
        check("data_out", data_out, e_wr ? mem_word(m_base + 16'(2 * m_recv)) : 16'h0);
        check("write_tag_array", write_tag_array, e_tag);
        check("fill_done", fill_done, e_tag);
        check("fill_count", fill_count, r ? m_fills : 16'h0);
        if (write_data_array === 1'b1) n_writes++;
        if (write_tag_array === 1'b1) n_tags++;
        if (fill_done === 1'b1) last_tag_cyc = cyc;
        if (memory_read === 1'b1) memq.push_back('{addr: memory_address, due: cyc + MEM_LATENCY - 1});
        @(posedge clk);
        if (!r) begin
            m_busy   = 1'b0;
            m_issued = 0;
            m_recv   = 0;
            m_fills  = '0;
        end else if (!m_busy) begin
            if (miss) begin
                m_busy   = 1'b1;
                m_base   = maddr & 16'hFFF0;
                m_issued = 0;
                m_recv   = 0;
                miss_cyc = cyc;
            end
        end else begin
            if (m_issued < WORDS_PER_BLOCK) m_issued++;
            if (v) begin
                if (m_recv == WORDS_PER_BLOCK - 1) begin
                    m_busy  = 1'b0;
                    m_fills = m_fills + 16'd1;
                end else begin
                    m_recv++;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_busy || memq.size() != 0) && n < budget) begin
            step(1'b1, 1'b0, 16'h0, 1'b1);
            n++;
        end
        check("drain_budget", (m_busy || memq.size() != 0) ? 1 : 0, 0);
    endtask

    initial begin
        int n;
        int w0;
        int t0;
        int target;
        rst               = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = '0;
        memory_data_valid = 1'b0;
        memory_data       = '0;
        @(posedge clk);
        #1;

        // Reset held: all outputs low, then the first cycle after reset.
        repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);

        // Single miss to 0x1236 with back-to-back returns.
        step(1'b1, 1'b1, 16'h1236, 1'b1);
        drain(64);
        check("t1_fill_count", fill_count, 16'd1);
        check("t1_tag_offset", last_tag_cyc - miss_cyc, 11);
        check("t1_writes", n_writes, 8);

        // Reset in the cycle the third word returns.
        step(1'b1, 1'b1, 16'h2468, 1'b1);
        n = 0;
        while (m_recv < 2 && n < 32) begin
            step(1'b1, 1'b0, 16'h0, 1'b1);
            n++;
        end
        check("t2_reached_word2", m_recv, 2);
        w0 = n_writes;
        t0 = n_tags;
        step(1'b0, 1'b0, 16'h0, 1'b1);
        drain(64);
        check("t2_no_more_writes", n_writes, w0);
        check("t2_no_tag", n_tags, t0);
        check("t2_fill_count", fill_count, 16'd0);
        step(1'b1, 1'b1, 16'h0040, 1'b1);
        drain(64);
        check("t2_refill_count", fill_count, 16'd1);
        check("t2_refill_tag_offset", last_tag_cyc - miss_cyc, 11);

        // Miss held high through the fill: exactly two fills back to back.
        target = int'(m_fills) + 2;
        n = 0;
        while (int'(m_fills) < target && n < 64) begin
            step(1'b1, 1'b1, 16'h3000, 1'b1);
            n++;
        end
        drain(64);
        check("t3_fill_count", fill_count, 16'd3);

        // Stray memory returns while idle must not touch the arrays.
        w0 = n_writes;
        t0 = n_tags;
        for (int i = 0; i < 4; i++) begin
            memq.push_back('{addr: 16'h0BAD + 16'(2 * i), due: cyc});
            step(1'b1, 1'b0, 16'h0, 1'b1);
        end
        drain(16);
        check("t4_idle_writes", n_writes, w0);
        check("t4_idle_tags", n_tags, t0);

        // Irregular returns with random gaps and random miss addresses.
        gap_max = 3;
        for (int k = 0; k < 4; k++) begin
            t0 = n_tags;
            step(1'b1, 1'b1, 16'($urandom), 1'b1);
            drain(200);
            check("t5_one_tag", n_tags - t0, 1);
        end
        gap_max = 0;
        check("t5_fill_count", fill_count, 16'd7);

        // fill_count wraps from 0xFFFF to 0.
        force dut.fill_cnt_q = 16'hFFFF;
        #1;
        release dut.fill_cnt_q;
        m_fills = 16'hFFFF;
        step(1'b1, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b1, 16'hABCE, 1'b1);
        drain(64);
        check("t6_wrap", fill_count, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
